// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory read/write port between two bus masters.
// Round-robin arbitration, 8/16-bit lane steering, misalignment and timeout
// errors reported with the one-cycle completion pulse.
//
// Handshake: a master raises pN_req_rdwr with address/size/we/data stable and
// holds it until it samples pN_data_ready (one-cycle pulse, pN_error valid in
// the same cycle); it must drop the request in the following cycle. Toward the
// memory, mem_req_rdwr stays high for the whole BUSY period and mem_data_ready
// is only honoured while BUSY.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  // port 0 (cpu data bus)
  input  logic                  p0_req_rdwr,
  input  logic [ADDR_WIDTH-1:0] p0_addr_in,
  input  logic                  p0_data_acc_sz,
  input  logic                  p0_data_inout_we,
  input  logic [DATA_WIDTH-1:0] p0_write_data,
  output logic [DATA_WIDTH-1:0] p0_read_data,
  output logic                  p0_data_ready,
  output logic                  p0_error,
  // port 1 (loader / dma)
  input  logic                  p1_req_rdwr,
  input  logic [ADDR_WIDTH-1:0] p1_addr_in,
  input  logic                  p1_data_acc_sz,
  input  logic                  p1_data_inout_we,
  input  logic [DATA_WIDTH-1:0] p1_write_data,
  output logic [DATA_WIDTH-1:0] p1_read_data,
  output logic                  p1_data_ready,
  output logic                  p1_error,
  // memory side
  output logic                  mem_req_rdwr,
  output logic [ADDR_WIDTH-1:0] mem_addr_in,
  output logic                  mem_data_acc_sz,
  output logic [7:0]            mem_write_data_in_8,
  output logic [DATA_WIDTH-1:0] mem_write_data_in_16,
  output logic                  mem_write_data_we_8,
  output logic                  mem_write_data_we_16,
  input  logic [7:0]            mem_read_data_out_8,
  input  logic [DATA_WIDTH-1:0] mem_read_data_out_16,
  input  logic                  mem_data_ready,
  // debug: current FSM state (0 idle, 1 busy, 2 done)
  output logic [1:0]            dbg_state
);

  // access size encoding shared with the cpu package
  localparam logic SZ_8  = 1'b0;
  localparam logic SZ_16 = 1'b1;
  localparam int   CW    = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state, state_d;
  logic                  grant, last_grant;
  logic                  err;
  logic                  mem_we;
  logic [CW-1:0]         tmo_cnt;

  logic                  any_req;
  logic                  sel;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_sz;
  logic                  sel_we;
  logic [DATA_WIDTH-1:0] sel_wd;
  logic                  misaligned;
  logic                  tmo_hit;
  logic [DATA_WIDTH-1:0] rd_cap;

  // arbitration choice, selected request fields and next-state decision
  always_comb begin
    any_req    = p0_req_rdwr | p1_req_rdwr;
    sel        = 1'b0;
    if (p0_req_rdwr && p1_req_rdwr) sel = ~last_grant;
    else if (p1_req_rdwr)           sel = 1'b1;
    sel_addr   = sel ? p1_addr_in       : p0_addr_in;
    sel_sz     = sel ? p1_data_acc_sz   : p0_data_acc_sz;
    sel_we     = sel ? p1_data_inout_we : p0_data_inout_we;
    sel_wd     = sel ? p1_write_data    : p0_write_data;
    misaligned = (sel_sz == SZ_16) && sel_addr[0];
    tmo_hit    = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
    rd_cap     = (mem_data_acc_sz == SZ_16) ? mem_read_data_out_16
                 : {{(DATA_WIDTH-8){1'b0}}, mem_read_data_out_8};
    state_d    = state;
    case (state)
      S_IDLE:  if (any_req) state_d = misaligned ? S_DONE : S_BUSY;
      S_BUSY:  if (mem_data_ready || tmo_hit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  // grant bookkeeping, latched request, timeout counter and read results
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant                <= 1'b0;
      last_grant           <= 1'b1;
      err                  <= 1'b0;
      mem_we               <= 1'b0;
      tmo_cnt              <= '0;
      mem_addr_in          <= '0;
      mem_data_acc_sz      <= 1'b0;
      mem_write_data_in_8  <= '0;
      mem_write_data_in_16 <= '0;
      p0_read_data         <= '0;
      p1_read_data         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            grant                <= sel;
            last_grant           <= sel;
            mem_addr_in          <= sel_addr;
            mem_data_acc_sz      <= sel_sz;
            mem_we               <= sel_we;
            mem_write_data_in_8  <= sel_wd[7:0];
            mem_write_data_in_16 <= sel_wd;
            tmo_cnt              <= '0;
            err                  <= misaligned;
            if (misaligned) begin
              if (sel) p1_read_data <= '0;
              else     p0_read_data <= '0;
            end
          end
        end
        S_BUSY: begin
          if (mem_data_ready) begin
            err <= 1'b0;
            // writes leave the requester's read register untouched
            if (!mem_we) begin
              if (grant) p1_read_data <= rd_cap;
              else       p0_read_data <= rd_cap;
            end
          end else if (tmo_hit) begin
            err <= 1'b1;
            if (grant) p1_read_data <= '0;
            else       p0_read_data <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // memory strobes and per-port completion, decoded from the state register
  always_comb begin
    mem_req_rdwr         = (state == S_BUSY);
    mem_write_data_we_8  = mem_req_rdwr && mem_we && (mem_data_acc_sz == SZ_8);
    mem_write_data_we_16 = mem_req_rdwr && mem_we && (mem_data_acc_sz == SZ_16);
    p0_data_ready        = (state == S_DONE) && !grant;
    p1_data_ready        = (state == S_DONE) &&  grant;
    p0_error             = p0_data_ready && err;
    p1_error             = p1_data_ready && err;
    dbg_state            = state;
  end

endmodule
